axi_memtest_master: RTL

AXI_MEMTEST_MASTER -- requirements
Module: axi_memtest_master

---
 rtl/axi_memtest_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_memtest_master.sv
// AXI4 memory test master: writes seed^word_address over the whole range in INCR
// bursts, reads it back, and counts data mismatches and response/framing errors.
module axi_memtest_master #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_ID_WIDTH  = 4,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_BURSTLEN  = 16
) (
  input  logic                     s_aclk,
  input  logic                     s_aresetn,
  input  logic                     start,
  input  logic [G_DATAWIDTH-1:0]   seed,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [15:0]              err_count,
  output logic [G_ADDRWIDTH-1:0]   first_err_addr,
  output logic [G_ID_WIDTH-1:0]    m_axi_awid,
  output logic [G_ADDRWIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [G_DATAWIDTH-1:0]   m_axi_wdata,
  output logic [G_DATAWIDTH/8-1:0] m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [G_ID_WIDTH-1:0]    m_axi_bid,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [G_ID_WIDTH-1:0]    m_axi_arid,
  output logic [G_ADDRWIDTH-1:0]   m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [G_ID_WIDTH-1:0]    m_axi_rid,
  input  logic [G_DATAWIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  localparam int NBURST  = G_MEMDEPTH / G_BURSTLEN;
  localparam int BEAT_W  = (G_BURSTLEN > 1) ? $clog2(G_BURSTLEN) : 1;
  localparam int BURST_W = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(G_BURSTLEN - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NBURST - 1);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic [BURST_W-1:0]      burst_q, burst_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [G_DATAWIDTH-1:0]  seed_q, seed_d;
  logic [15:0]             err_q, err_d;
  logic [G_ADDRWIDTH-1:0]  fea_q, fea_d;
  logic                    done_q, done_d, pass_q, pass_d;

  logic [G_ADDRWIDTH-1:0]  base_addr, word_addr, err_addr;
  logic [G_DATAWIDTH-1:0]  pattern;
  logic [1:0]              err_inc;
  logic                    last_beat, last_burst;
  logic                    unused_ids;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign base_addr  = G_ADDRWIDTH'(burst_q) * G_ADDRWIDTH'(G_BURSTLEN);
  assign word_addr  = base_addr + G_ADDRWIDTH'(beat_q);
  assign pattern    = seed_q ^ G_DATAWIDTH'(word_addr);
  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_burst = (burst_q == LAST_BURST);
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = base_addr;
  assign m_axi_awlen   = 8'(G_BURSTLEN - 1);
  assign m_axi_awsize  = 3'($clog2(G_DATAWIDTH / 8));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = (state_q == WADDR);
  assign m_axi_wdata   = pattern;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = last_beat;
  assign m_axi_wvalid  = (state_q == WDATA);
  assign m_axi_bready  = (state_q == WRESP);
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = base_addr;
  assign m_axi_arlen   = 8'(G_BURSTLEN - 1);
  assign m_axi_arsize  = 3'($clog2(G_DATAWIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == RADDR);
  assign m_axi_rready  = (state_q == RDATA);

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    seed_d   = seed_q;
    err_d    = err_q;
    fea_d    = fea_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_inc  = 2'd0;
    err_addr = base_addr;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          seed_d  = seed;
          err_d   = '0;
          fea_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          burst_d = '0;
          beat_d  = '0;
          state_d = WADDR;
        end
      end
      WADDR: if (m_axi_awready) state_d = WDATA;
      WDATA: begin
        if (m_axi_wready) begin
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          err_inc = {1'b0, (m_axi_bresp != 2'b00)};
          burst_d = last_burst ? '0 : burst_q + 1'b1;
          state_d = last_burst ? RADDR : WADDR;
        end
      end
      RADDR: if (m_axi_arready) state_d = RDATA;
      RDATA: begin
        if (m_axi_rvalid) begin
          // a bad beat and a misplaced/missing rlast are counted separately
          err_addr = word_addr;
          err_inc  = {1'b0, (m_axi_rdata != pattern) || (m_axi_rresp != 2'b00)}
                   + {1'b0, (m_axi_rlast != last_beat)};
          beat_d   = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) begin
            burst_d = last_burst ? '0 : burst_q + 1'b1;
            state_d = last_burst ? DONE : RADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_inc != 2'd0) begin
      err_d = sat_add(err_q, err_inc);
      if (err_q == 16'd0) fea_d = err_addr;
    end
    if (state_q == RDATA && state_d == DONE) begin
      done_d = 1'b1;
      pass_d = (err_d == 16'd0);
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= IDLE;
      burst_q <= '0;
      beat_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

endmodule
